mac_unit_stripes_seq: RTL and testbench

Self-sequencing, parametrised bit-serial (Stripes-style) dot-product unit. It is the successor to the 16-lane bit-serial MAC and supports any power-of-two lane count, runtime weight precision, an internal MSB-first bit sequencer, a valid/ready handshake on both sides, and three result modes: plain, accumulate and max-pool. It sits between the activation/weight buffers and the output/pooling stage of the PE array.

---
 rtl/mac_unit_stripes_seq.sv | 159 +++++++++++++++
 tb/tb_mac_unit_stripes_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mac_unit_stripes_seq.sv
// Bit-serial (Stripes-style) dot-product unit. Weights are walked MSB-first, one bit-plane per cycle.
// The result is then finished as plain, accumulate or max-pool and held until downstream accepts it.
`timescale 1ns/1ps
module mac_unit_stripes_seq #(
    parameter int DATA_WIDTH   = 8,
    parameter int VEC_LENGTH   = 16,
    parameter int RESULT_WIDTH = 2*DATA_WIDTH,
    parameter int ACC_WIDTH    = 2*DATA_WIDTH + $clog2(VEC_LENGTH) + 1,
    parameter int PREC_WIDTH   = $clog2(DATA_WIDTH) + 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act_in,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  w_in,
    input  logic [PREC_WIDTH-1:0]                  w_prec,
    input  logic [1:0]                             mode,
    input  logic signed [RESULT_WIDTH-1:0]         result_prev,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [RESULT_WIDTH-1:0]         result,
    output logic                                   busy
);
    localparam int LOG2   = $clog2(VEC_LENGTH);
    localparam int IDX_W  = $clog2(DATA_WIDTH);
    localparam int PSUM_W = DATA_WIDTH + LOG2;

    localparam logic signed [ACC_WIDTH:0] RMAX =
        {{(ACC_WIDTH+2-RESULT_WIDTH){1'b0}}, {(RESULT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] RMIN =
        {{(ACC_WIDTH+2-RESULT_WIDTH){1'b1}}, {(RESULT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, COMPUTE, OUT} state_t;

    state_t                          state_q, state_d;
    logic [PREC_WIDTH-1:0]           bit_q, bit_d;
    logic [PREC_WIDTH-1:0]           top_q;
    logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic signed [RESULT_WIDTH-1:0]  result_q, result_d;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] act_q, w_q;
    logic [1:0]                      mode_q;
    logic signed [RESULT_WIDTH-1:0]  prev_q;

    logic                            accept;
    logic [PREC_WIDTH-1:0]           prec_eff;
    logic [VEC_LENGTH-1:0]           wbit;
    logic signed [PSUM_W-1:0]        psum;
    logic signed [ACC_WIDTH-1:0]     psum_ext, term, acc_step;
    logic signed [RESULT_WIDTH-1:0]  s_plain, s_accum, s_max, finished;

    function automatic logic signed [RESULT_WIDTH-1:0] sat(input logic signed [ACC_WIDTH:0] x);
        if (x > RMAX)      return RMAX[RESULT_WIDTH-1:0];
        else if (x < RMIN) return RMIN[RESULT_WIDTH-1:0];
        else               return x[RESULT_WIDTH-1:0];
    endfunction

    assign accept   = in_valid && (state_q == IDLE);
    assign prec_eff = (w_prec == '0 || w_prec > PREC_WIDTH'(DATA_WIDTH)) ?
                      PREC_WIDTH'(DATA_WIDTH) : w_prec;

    always_comb begin
        wbit = '0;
        for (int j = 0; j < VEC_LENGTH; j++) begin
            wbit[j] = w_q[j][bit_q[IDX_W-1:0]];
        end
    end

    // Balanced adder tree; each level is one bit wider than the one below it.
    for (genvar l = 0; l <= LOG2; l++) begin : g_lvl
        logic signed [DATA_WIDTH+l-1:0] s [VEC_LENGTH>>l];
        for (genvar i = 0; i < (VEC_LENGTH >> l); i++) begin : g_node
            if (l == 0) begin : g_leaf
                assign s[i] = wbit[i] ? $signed(act_q[i]) : {DATA_WIDTH{1'b0}};
            end else begin : g_add
                assign s[i] = (DATA_WIDTH+l)'(g_lvl[l-1].s[2*i]) +
                              (DATA_WIDTH+l)'(g_lvl[l-1].s[2*i+1]);
            end
        end
    end

    assign psum     = g_lvl[LOG2].s[0];
    assign psum_ext = ACC_WIDTH'(psum);
    assign term     = (bit_q == top_q) ? -psum_ext : psum_ext;
    assign acc_step = (acc_q <<< 1) + term;

    assign s_plain  = sat((ACC_WIDTH+1)'(acc_step));
    assign s_accum  = sat((ACC_WIDTH+1)'(acc_step) + (ACC_WIDTH+1)'(prev_q));
    assign s_max    = (s_plain > prev_q) ? s_plain : prev_q;

    always_comb begin
        finished = s_plain;
        case (mode_q)
            2'd1:    finished = s_accum;
            2'd2:    finished = s_max;
            default: finished = s_plain;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = '0;
                    bit_d   = prec_eff - 1'b1;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                acc_d = acc_step;
                if (bit_q == '0) begin
                    state_d  = OUT;
                    result_d = finished;
                end else begin
                    bit_d = bit_q - 1'b1;
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Operand capture needs no reset: it is only read after an accept has loaded it.
    always_ff @(posedge clk) begin
        if (accept) begin
            act_q  <= act_in;
            w_q    <= w_in;
            mode_q <= mode;
            prev_q <= result_prev;
            top_q  <= prec_eff - 1'b1;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign result    = result_q;

endmodule

// File: tb/tb_mac_unit_stripes_seq.sv
// Scoreboard bench for mac_unit_stripes_seq: directed operand sets with hand-computed results,
// plus timing, backpressure and asynchronous-reset checks.
`timescale 1ns/1ps
module tb_mac_unit_stripes_seq;
    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid, in_ready;
    logic [15:0][7:0]      act_in, w_in;
    logic [3:0]            w_prec;
    logic [1:0]            mode;
    logic signed [15:0]    result_prev, result;
    logic                  out_valid, out_ready, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int sb[$];

    mac_unit_stripes_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .act_in(act_in), .w_in(w_in), .w_prec(w_prec), .mode(mode),
        .result_prev(result_prev), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every accepted output is compared against the oldest expected value.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty: output %0d with no expected value", result);
            end else begin
                check("result", result, sb.pop_front());
            end
        end
    end

    task automatic fill(input int a, input int w);
        for (int j = 0; j < 16; j++) begin
            act_in[j] = a[7:0];
            w_in[j]   = w[7:0];
        end
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (k == 50) check("wait_idle_timeout", 0, 1);
    endtask

    task automatic start_op(input int prec, input int md, input int prev, input int exp, input bit push);
        wait_idle();
        @(posedge clk); #2;
        w_prec      = prec[3:0];
        mode        = md[1:0];
        result_prev = prev[15:0];
        in_valid    = 1'b1;
        if (push) sb.push_back(exp);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input int prec, input int md, input int prev, input int exp, input int lat);
        int m;
        start_op(prec, md, prev, exp, 1'b1);
        for (m = 0; m < 40; m++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("latency", m, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b0; in_valid = 1'b0; act_in = '0; w_in = '0;
        w_prec = '0; mode = '0; result_prev = '0; out_ready = 1'b1;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        @(posedge clk); #2 reset = 1'b0;

        // Plain mode, full precision, with per-cycle handshake timing
        fill(1, 1);
        start_op(8, 0, 0, 16, 1'b1);
        for (int m = 0; m <= 9; m++) begin
            @(negedge clk);
            check("t1_busy", busy, (m <= 8) ? 1 : 0);
            check("t1_out_valid", out_valid, (m == 8) ? 1 : 0);
            check("t1_in_ready", in_ready, (m > 8) ? 1 : 0);
        end

        // Saturation at both rails
        fill(-128, -128);
        run_op(8, 0, 0, 32767, 8);
        fill(127, -128);
        run_op(8, 0, 0, -32768, 8);

        // Low precision, including P=0 treated as full width
        fill(3, 8'hFF);
        run_op(2, 0, 0, -48, 2);
        run_op(1, 0, 0, -48, 1);
        run_op(0, 0, 0, -48, 8);

        // Accumulate and max-pool
        act_in = '0; w_in = '0;
        act_in[0] = 8'd5; w_in[0] = 8'd7;
        run_op(4, 1, 100, 135, 4);
        run_op(4, 2, 100, 100, 4);
        run_op(4, 2, -200, 35, 4);
        run_op(4, 1, 32767, 32767, 4);
        run_op(4, 3, 100, 35, 4);

        // Output backpressure with a busy input bus
        wait_idle();
        out_ready = 1'b0;
        run_op(4, 0, 0, 35, 4);
        for (k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            in_valid  = 1'b1;
            act_in[1] = 8'(k + 1);
            w_in[1]   = 8'hFF;
            w_prec    = 4'(k + 1);
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_result_hold", result, 35);
        end
        @(posedge clk); #2;
        fill(2, 3);
        w_prec = 4'd8; mode = 2'd0;
        sb.push_back(96);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_still_out", in_ready, 0);
        @(negedge clk);
        check("bp_idle_ready", in_ready, 1);
        check("bp_idle_valid", out_valid, 0);
        @(posedge clk); #2 in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", busy, 1);
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("bp_done", out_valid, 1);

        // Asynchronous reset in the middle of a computation
        fill(5, -1);
        start_op(8, 0, 0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_result", result, 0);
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_busy", busy, 0);
        @(posedge clk); #2 reset = 1'b0;
        fill(2, 3);
        run_op(8, 0, 0, 96, 8);

        wait_idle();
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
